svreal_mac_mod: RTL and testbench

Pipelined fixed-point multiply-accumulate over svreal-format operands. It computes a dot product of `len` consecutive (a, b) pairs and emits one svreal result per batch in the output format. Saturation and overflow reporting are configurable. It sits beside the svreal arithmetic and DFF primitives, serving filter and integrator datapaths that need a registered, batched accumulate instead of a chain of combinational adders.

---
 rtl/svreal_mac_mod.sv | 197 +++++++++++++++++++
 tb/tb_svreal_mac_mod.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/svreal_mac_mod.sv
// -----------------------------------------------------------------------------
// svreal_mac_mod
//   Pipelined fixed-point multiply-accumulate over svreal-format operands.
//   Each batch takes `len` valid (a, b) pairs, forms their dot product in a
//   guarded accumulator aligned to the output exponent, and emits one
//   registered svreal significand per batch.
//
//   Stage S1 registers the raw product. Between S1 and S2 the product is
//   shifted from exponent (a_exponent + b_exponent) to c_exponent and
//   clamped into the accumulator. Stage S2 accumulates and, on the last pair
//   of a batch, fits the sum into c_significand_width bits.
//
// Ports
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   cke             : clock enable; every register holds while low
//   clear           : synchronous batch abort (acts even when cke is low)
//   in_valid        : a/b pair valid this cycle
//   a_significand   : signed significand of a      (a_significand_width)
//   a_exponent      : signed exponent of a         (16, quasi-static)
//   b_significand   : signed significand of b      (b_significand_width)
//   b_exponent      : signed exponent of b         (16, quasi-static)
//   c_exponent      : signed exponent of result    (16, quasi-static)
//   c_significand   : registered signed result     (c_significand_width)
//   out_valid       : one-cycle result pulse
//   overflow        : overflow qualifier for the current result
// -----------------------------------------------------------------------------
module svreal_mac_mod #(
  parameter int a_significand_width = 8,
  parameter int b_significand_width = 8,
  parameter int c_significand_width = 16,
  parameter int guard_bits          = 4,
  parameter int len                 = 4,
  parameter bit saturate            = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cke,
  input  logic                                  clear,
  input  logic                                  in_valid,
  input  logic signed [a_significand_width-1:0] a_significand,
  input  logic signed [15:0]                    a_exponent,
  input  logic signed [b_significand_width-1:0] b_significand,
  input  logic signed [15:0]                    b_exponent,
  input  logic signed [15:0]                    c_exponent,
  output logic signed [c_significand_width-1:0] c_significand,
  output logic                                  out_valid,
  output logic                                  overflow
);

  localparam int P_W    = a_significand_width + b_significand_width;
  localparam int C_W    = c_significand_width;
  localparam int ACC_W  = c_significand_width + guard_bits;
  // Wide enough to hold the product shifted left by up to ACC_W without loss.
  localparam int WIDE_W = ACC_W + P_W + 1;
  localparam int CNT_W  = (len > 1) ? $clog2(len) : 1;

  // State
  logic signed [P_W-1:0]   p_q,         p_d;
  logic                    p_valid_q,   p_valid_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;
  logic signed [ACC_W-1:0] acc_q,       acc_d;
  logic                    sticky_q,    sticky_d;
  logic signed [C_W-1:0]   c_sig_q,     c_sig_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overflow_q,  overflow_d;

  // Alignment
  logic signed [17:0]       shift_s;
  logic [17:0]              shift_r;
  logic                     big_shift;
  logic signed [WIDE_W-1:0] p_wide;
  logic signed [WIDE_W-1:0] shifted;
  logic                     acc_fits;
  logic signed [ACC_W-1:0]  aligned;
  logic                     aligned_ovf;

  // Accumulate and output fit
  logic                    first_pair;
  logic                    batch_end;
  logic signed [ACC_W:0]   sum_wide;
  logic                    sum_ovf;
  logic signed [ACC_W-1:0] sum_sat;
  logic                    fit_ovf;
  logic signed [C_W-1:0]   fit_val;
  logic                    pair_ovf;

  // Exponent difference: 18 bits cover the full range of a + b - c.
  assign shift_s = {{2{a_exponent[15]}}, a_exponent}
                 + {{2{b_exponent[15]}}, b_exponent}
                 - {{2{c_exponent[15]}}, c_exponent};

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    p_wide    = {{(WIDE_W-P_W){p_q[P_W-1]}}, p_q};
    shift_r   = '0;
    big_shift = 1'b0;
    shifted   = p_wide;
    if (!shift_s[17]) begin
      // Any left shift past ACC_W cannot fit unless the product is zero.
      if (shift_s > $signed(18'(ACC_W))) big_shift = 1'b1;
      else                               shifted   = p_wide <<< shift_s;
    end else begin
      shift_r = -shift_s;
      // Arithmetic right shift floors toward -inf; far shifts leave only sign.
      if (shift_r >= 18'(WIDE_W)) shifted = {WIDE_W{p_q[P_W-1]}};
      else                        shifted = p_wide >>> shift_r;
    end
    acc_fits    = (&shifted[WIDE_W-1:ACC_W-1]) | ~(|shifted[WIDE_W-1:ACC_W-1]);
    aligned_ovf = big_shift ? (p_q != '0) : ~acc_fits;
    aligned     = aligned_ovf ? {p_q[P_W-1], {(ACC_W-1){~p_q[P_W-1]}}}
                              : shifted[ACC_W-1:0];
  end

  always_comb begin
    first_pair = (cnt_q == '0);
    batch_end  = p_valid_q && (cnt_q == CNT_W'(len - 1));

    // One bit wider than acc so a single add can never wrap silently.
    sum_wide = first_pair ? {aligned[ACC_W-1], aligned}
                          : {acc_q[ACC_W-1], acc_q} + {aligned[ACC_W-1], aligned};
    sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum_sat  = sum_ovf ? {sum_wide[ACC_W], {(ACC_W-1){~sum_wide[ACC_W]}}}
                       : sum_wide[ACC_W-1:0];

    fit_ovf  = ~((&sum_sat[ACC_W-1:C_W-1]) | ~(|sum_sat[ACC_W-1:C_W-1]));
    if (fit_ovf && saturate) fit_val = {sum_sat[ACC_W-1], {(C_W-1){~sum_sat[ACC_W-1]}}};
    else                     fit_val = sum_sat[C_W-1:0];

    pair_ovf = aligned_ovf | sum_ovf;
  end

  always_comb begin
    p_d         = p_q;
    p_valid_d   = p_valid_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    c_sig_d     = c_sig_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;

    if (clear) begin
      // Abort wins over cke and batch end; the last result stays visible.
      p_valid_d   = 1'b0;
      cnt_d       = '0;
      acc_d       = '0;
      sticky_d    = 1'b0;
      out_valid_d = 1'b0;
    end else if (cke) begin
      p_d         = P_W'(a_significand) * P_W'(b_significand);
      p_valid_d   = in_valid;
      out_valid_d = 1'b0;
      if (p_valid_q) begin
        acc_d    = sum_sat;
        // The flag restarts on the first pair of each batch.
        sticky_d = (first_pair ? 1'b0 : sticky_q) | pair_ovf;
        if (batch_end) begin
          cnt_d       = '0;
          sticky_d    = 1'b0;
          c_sig_d     = fit_val;
          out_valid_d = 1'b1;
          overflow_d  = (first_pair ? 1'b0 : sticky_q) | pair_ovf | fit_ovf;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      p_q         <= '0;
      p_valid_q   <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      c_sig_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      p_q         <= p_d;
      p_valid_q   <= p_valid_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      c_sig_q     <= c_sig_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign c_significand = c_sig_q;
  assign out_valid     = out_valid_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_svreal_mac_mod.sv
// -----------------------------------------------------------------------------
// tb_svreal_mac_mod
//   Self-checking bench for svreal_mac_mod. Two instances share every input:
//   one saturating, one wrapping. A batch-level reference model computes the
//   expected result of each batch with plain integer arithmetic; directed
//   steps cover the listed scenarios, followed by randomized traffic over
//   several exponent settings.
// -----------------------------------------------------------------------------
module tb_svreal_mac_mod;

  localparam int LEN   = 4;
  localparam int C_W   = 16;
  localparam int ACC_W = 20;

  logic               clk = 1'b0;
  logic               rst_n, cke, clear, in_valid;
  logic signed [7:0]  a_sig, b_sig;
  logic signed [15:0] a_exp, b_exp, c_exp;
  logic signed [15:0] c_sat, c_wrap;
  logic               valid_sat, valid_wrap, ov_sat, ov_wrap;

  svreal_mac_mod #(.saturate(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cke(cke), .clear(clear), .in_valid(in_valid),
    .a_significand(a_sig), .a_exponent(a_exp),
    .b_significand(b_sig), .b_exponent(b_exp),
    .c_significand(c_sat), .c_exponent(c_exp),
    .out_valid(valid_sat), .overflow(ov_sat)
  );

  svreal_mac_mod #(.saturate(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .cke(cke), .clear(clear), .in_valid(in_valid),
    .a_significand(a_sig), .a_exponent(a_exp),
    .b_significand(b_sig), .b_exponent(b_exp),
    .c_significand(c_wrap), .c_exponent(c_exp),
    .out_valid(valid_wrap), .overflow(ov_wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses[$];

  // Reference model state (one batch in flight)
  int     m_cnt = 0;
  longint m_acc = 0;
  bit     m_ov  = 1'b0;
  bit     due   = 1'b0;
  longint due_c_sat, due_c_wrap;
  bit     due_ov;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clamp_bits(input longint v, input int w, output bit ov);
    longint lo, hi;
    lo = -(longint'(1) << (w - 1));
    hi = -lo - 1;
    ov = (v < lo) || (v > hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic longint wrap_bits(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // Product value re-expressed in units of 2**c_exponent, floored.
  function automatic longint align_ref(input int a, input int b);
    longint prod, d, q;
    int s;
    prod = longint'(a) * longint'(b);
    s    = int'(a_exp) + int'(b_exp) - int'(c_exp);
    if (s >= 0) begin
      if (s > 40) return (prod == 0) ? 0 : ((prod > 0) ? (longint'(1) << 41) : -(longint'(1) << 41));
      return prod * (longint'(1) << s);
    end
    if (-s > 40) return (prod < 0) ? -1 : 0;
    d = longint'(1) << (-s);
    q = prod / d;
    if ((prod % d != 0) && (prod < 0)) q -= 1;
    return q;
  endfunction

  task automatic consume(input int a, input int b);
    longint v, raw;
    bit ov1, ov2, ovf;
    v   = clamp_bits(align_ref(a, b), ACC_W, ov1);
    raw = (m_cnt == 0) ? v : m_acc + v;
    m_ov  = (m_cnt == 0) ? ov1 : (m_ov | ov1);
    m_acc = clamp_bits(raw, ACC_W, ov2);
    m_ov  = m_ov | ov2;
    m_cnt++;
    if (m_cnt == LEN) begin
      due        = 1'b1;
      due_c_sat  = clamp_bits(m_acc, C_W, ovf);
      due_c_wrap = wrap_bits(m_acc, C_W);
      due_ov     = m_ov | ovf;
      m_cnt      = 0;
    end
  endtask

  // Drive one cycle (cke high), then check outputs 1 time unit after the edge.
  task automatic run_cycle(input bit iv, input logic signed [7:0] a,
                           input logic signed [7:0] b, input bit clr);
    in_valid = iv;
    a_sig    = a;
    b_sig    = b;
    clear    = clr;
    @(posedge clk);
    #1;
    cyc++;
    if (clr) begin
      due   = 1'b0;
      m_cnt = 0;
    end
    check("out_valid_sat", valid_sat, due);
    check("out_valid_wrap", valid_wrap, due);
    if (valid_sat === 1'b1) pulses.push_back(cyc);
    if (due) begin
      check("c_sat", c_sat, 32'(due_c_sat));
      check("c_wrap", c_wrap, 32'(due_c_wrap));
      check("ov_sat", ov_sat, due_ov);
      check("ov_wrap", ov_wrap, due_ov);
    end
    due = 1'b0;
    if (!clr && iv) consume(int'(a), int'(b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 8'sd0, 8'sd0, 1'b0);
  endtask

  initial begin
    int start;
    rst_n = 1'b0; cke = 1'b1; clear = 1'b0; in_valid = 1'b0;
    a_sig = '0; b_sig = '0;
    a_exp = -16'sd4; b_exp = -16'sd4; c_exp = -16'sd8;

    // Reset state
    #1;
    check("rst_c_sat", c_sat, 0);
    check("rst_valid", valid_sat, 0);
    check("rst_ov", ov_sat, 0);
    check("rst_c_wrap", c_wrap, 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    #2;

    // Basic dot product: 4 x (1.0 * 2.0) = 8.0
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 8'sd16, 8'sd32, 1'b0);
    idle(2);
    check("basic_c", c_sat, 2048);
    check("basic_ov", ov_sat, 0);

    // Positive overflow, both output modes
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 8'sd127, 8'sd127, 1'b0);
    idle(2);
    check("possat_c", c_sat, 32767);
    check("possat_ov", ov_sat, 1);
    check("poswrap_c", c_wrap, -1020);
    check("poswrap_ov", ov_wrap, 1);

    // Negative saturation
    for (int i = 0; i < 4; i++) run_cycle(1'b1, -8'sd128, 8'sd127, 1'b0);
    idle(2);
    check("negsat_c", c_sat, -32768);
    check("negsat_ov", ov_sat, 1);

    // Right shift by 2
    c_exp = -16'sd6;
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 8'sd16, 8'sd32, 1'b0);
    idle(2);
    check("rshift_c", c_sat, 512);
    check("rshift_ov", ov_sat, 0);
    c_exp = -16'sd8;
    idle(2);

    // Gap of 3 cycles after the 2nd pair
    pulses.delete();
    start = cyc;
    for (int i = 0; i < 2; i++) run_cycle(1'b1, 8'sd1, 8'sd1, 1'b0);
    idle(3);
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 8'sd1, 8'sd1, 1'b0);
    idle(3);
    check("gap_pulses", pulses.size(), 2);
    if (pulses.size() == 2) begin
      check("gap_first_at", pulses[0] - start, 8);
      check("gap_second_at", pulses[1] - start, 12);
    end
    check("gap_c", c_sat, 4);

    // Back-to-back batches
    pulses.delete();
    start = cyc;
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 8'sd1, 8'sd1, 1'b0);
    idle(3);
    check("b2b_pulses", pulses.size(), 2);
    if (pulses.size() == 2) begin
      check("b2b_first_at", pulses[0] - start, 5);
      check("b2b_spacing", pulses[1] - pulses[0], 4);
    end

    // Clear mid-batch, pair under clear dropped
    for (int i = 0; i < 2; i++) run_cycle(1'b1, 8'sd100, 8'sd100, 1'b0);
    run_cycle(1'b1, 8'sd100, 8'sd100, 1'b1);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 8'sd1, 8'sd2, 1'b0);
    idle(2);
    check("clear_c", c_sat, 8);
    check("clear_ov", ov_sat, 0);

    // Asynchronous reset mid-cycle during a batch
    for (int i = 0; i < 2; i++) run_cycle(1'b1, 8'sd16, 8'sd32, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_c", c_sat, 0);
    check("arst_valid", valid_sat, 0);
    check("arst_ov", ov_sat, 0);
    m_cnt = 0;
    due   = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 8'sd16, 8'sd32, 1'b0);
    idle(2);
    check("arst_after_c", c_sat, 2048);

    // cke low holds out_valid and c while junk pairs are presented
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 8'sd16, 8'sd32, 1'b0);
    run_cycle(1'b0, 8'sd0, 8'sd0, 1'b0);
    cke = 1'b0;
    in_valid = 1'b1; a_sig = 8'sd5; b_sig = 8'sd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cyc++;
      check("cke_valid_hold", valid_sat, 1);
      check("cke_c_hold", c_sat, 2048);
    end
    cke = 1'b1;
    idle(2);

    // Randomized traffic over several alignment settings
    for (int e = 0; e < 5; e++) begin
      run_cycle(1'b0, 8'sd0, 8'sd0, 1'b1);
      idle(1);
      case (e)
        0: begin a_exp = -16'sd4;  b_exp = -16'sd4; end
        1: begin a_exp = -16'sd3;  b_exp = -16'sd2; end
        2: begin a_exp = -16'sd6;  b_exp = -16'sd5; end
        3: begin a_exp = 16'sd4;   b_exp = 16'sd4;  end
        default: begin a_exp = -16'sd20; b_exp = -16'sd8; end
      endcase
      c_exp = -16'sd8;
      for (int i = 0; i < 60; i++)
        run_cycle($urandom_range(3) != 0, 8'($urandom), 8'($urandom),
                  $urandom_range(31) == 0);
      idle(3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
